shr_seq_arbiter: RTL and testbench
==================================

// Module: shr_seq_arbiter
// PURPOSE
//  Shares one 1-bit-per-cycle shift-right step between NUM_REQ requesters.
//  Round-robin arbitration picks one request; the shift is done over several cycles.
//  Each request is a data word plus a shift amount. One result is returned per request,
//  tagged with the requester id.
//  Sits between the dpgen-generated datapath and the library SHR component (sh_amt tied to 1).
// PARAMETERS
//  DATAWIDTH  16  operand/result width
//  NUM_REQ    2   number of requesters (2..8)
//  AMTWIDTH   4   shift-amount width, = $clog2(DATAWIDTH)
//  IDWIDTH    1   requester-id width, = max(1,$clog2(NUM_REQ))
// PORTS
//  Clk        in   1                  clock, rising edge
//  Rst        in   1                  synchronous, active-low reset
//  req_valid  in   NUM_REQ            per-requester request valid
//  req_a      in   NUM_REQ*DATAWIDTH  packed operands; requester i at [i*DATAWIDTH +: DATAWIDTH]
//  req_amt    in   NUM_REQ*AMTWIDTH   packed shift amounts; same packing
//  req_ready  out  NUM_REQ            one-hot accept pulse
//  rsp_valid  out  1                  result valid
//  rsp_ready  in   1                  result consumer ready
//  rsp_d      out  DATAWIDTH          a >> amt, logical (zero fill)
//  rsp_id     out  IDWIDTH            index of the requester that was served
//  busy       out  1                  high whenever state != IDLE
// BEHAVIOUR
//  Reset (Rst==0 at a Clk edge):
//   - state=IDLE, rr_ptr=0, acc=0, cnt=0.
//   - rsp_valid=0, rsp_d=0, rsp_id=0, req_ready=0, busy=0.
//   - Reset mid-operation abandons the in-flight request; no response is produced for it.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//   - If any req_valid, grant the first valid index at or after rr_ptr, wrapping.
//   - In the same cycle, req_ready[g] is asserted combinationally and is 1 only in that cycle.
//   - On the edge, capture acc<=req_a[g], cnt<=req_amt[g], id<=g.
//   - Next state is DONE if req_amt[g]==0, else SHIFT.
//   - req_ready is never asserted outside IDLE; requesters hold valid/data until accepted.
//  SHIFT: each cycle acc<=acc>>1 and cnt<=cnt-1. Go to DONE when cnt==1, i.e. after exactly amt cycles.
//  DONE:
//   - rsp_valid=1; rsp_d=acc and rsp_id=id, both held stable until rsp_ready.
//   - On rsp_valid&&rsp_ready: rr_ptr<=(id+1) mod NUM_REQ, then go to IDLE.
//  Latency from accept edge to first rsp_valid: amt+1 cycles (amt==0 gives 1 cycle).
//  Throughput: one request per amt+2 cycles minimum; there is no overlap between requests.
//  Fairness: a requester held valid is served within NUM_REQ grants.
//  rsp_ready held low stalls in DONE indefinitely; no data loss.
//  Amount range 0..DATAWIDTH-1 is fully covered by AMTWIDTH; no saturation case exists.
// CONFIGURATION
//  SHR_EARLY_ZERO_EN:
//   - Defined: in SHIFT, if acc==0 (or acc>>1==0 on this step), go to DONE immediately.
//     rsp_d is still the correct value 0, and latency is shortened.
//   - Undefined: latency is always exactly amt+1 cycles.
// STRUCTURE
//  Shared package shr_seq_pkg:
//   - state enum localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2.
//   - function clog2 used for AMTWIDTH/IDWIDTH.
//  Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant,
//   grant index and any.
//  The shift step is one instance of the library SHR component, DATAWIDTH passed through,
//   sh_amt=1'b1.
// TESTING
//  1. Rst low 2 cycles mid-SHIFT (req0 a=16'hF000, amt=8):
//     -> rsp_valid never rises, busy=0, rr_ptr=0 after release.
//  2. req0 a=16'h8000, amt=15 -> ready0 pulse; rsp_d=16'h0001, rsp_id=0, 16 cycles after accept.
//  3. req1 a=16'hABCD, amt=0 -> rsp_d=16'hABCD, rsp_id=1, rsp_valid one cycle after accept.
//  4. req0 and req1 held valid, amt=4, a=16'h00F0 each:
//     -> grants alternate 0,1,0,1; every rsp_d=16'h000F.
//  5. rsp_ready low 10 cycles in DONE -> rsp_d/rsp_id stable; req_ready stays 0;
//     released -> IDLE next cycle.
//  6. SHR_EARLY_ZERO_EN defined, a=16'h0003, amt=12 -> rsp_d=0, rsp_valid after 3 cycles
//     (undefined: after 13).

Source files
------------

// File: rtl/shr_seq_arbiter_pkg.sv
// rtl/shr_seq_arbiter_pkg.sv - shared state encoding and width helper for the shift-right arbiter
package shr_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/shr_seq_arbiter_if.sv
// rtl/shr_seq_arbiter_if.sv - request/response bundle between requesters and the shift-right arbiter
interface shr_seq_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int DATAWIDTH = 16,
    parameter int AMTWIDTH  = 4,
    parameter int IDWIDTH   = 1
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*DATAWIDTH-1:0] req_a;
    logic [NUM_REQ*AMTWIDTH-1:0]  req_amt;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [DATAWIDTH-1:0]         rsp_d;
    logic [IDWIDTH-1:0]           rsp_id;
    logic                         busy;

    modport master (
        output req_valid, req_a, req_amt, rsp_ready,
        input  req_ready, rsp_valid, rsp_d, rsp_id, busy
    );

    modport slave (
        input  req_valid, req_a, req_amt, rsp_ready,
        output req_ready, rsp_valid, rsp_d, rsp_id, busy
    );
endinterface

// File: rtl/shr_seq_arbiter_rr.sv
// rtl/shr_seq_arbiter_rr.sv - round-robin grant: first valid index at or after ptr, wrapping
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDWIDTH = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDWIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDWIDTH-1:0] idx,
    output logic               any
);
    // Lowest valid index overall is the wrap-around fallback; lowest at/after ptr overrides it.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDWIDTH'(i);
                any = 1'b1;
            end
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (IDWIDTH'(i) >= ptr)) idx = IDWIDTH'(i);
        end
        if (any) grant[idx] = 1'b1;
    end
endmodule

// File: rtl/shr_seq_arbiter_shr.sv
// rtl/shr_seq_arbiter_shr.sv - library SHR component: combinational logical shift right
module SHR #(
    parameter int DATAWIDTH = 16
) (
    input  logic [DATAWIDTH-1:0] a,
    input  logic                 sh_amt,
    output logic [DATAWIDTH-1:0] d
);
    assign d = a >> sh_amt;
endmodule

// File: rtl/shr_seq_arbiter.sv
// rtl/shr_seq_arbiter.sv - round-robin shared 1-bit-per-cycle shift-right; SHR_EARLY_ZERO_EN ends shifting once the value is zero
module shr_seq_arbiter
    import shr_seq_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int NUM_REQ   = 2,
    parameter int AMTWIDTH  = clog2(DATAWIDTH),
    parameter int IDWIDTH   = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic             Clk,
    input  logic             Rst,
    shr_seq_arbiter_if.slave bus
);
    state_t               state, state_nxt;
    logic [DATAWIDTH-1:0] acc, acc_nxt, acc_shr;
    logic [AMTWIDTH-1:0]  cnt, cnt_nxt;
    logic [IDWIDTH-1:0]   id, id_nxt;
    logic [IDWIDTH-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [IDWIDTH-1:0]   grant_idx;
    logic                 grant_any;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDWIDTH(IDWIDTH)) u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    SHR #(.DATAWIDTH(DATAWIDTH)) u_shr (
        .a      (acc),
        .sh_amt (1'b1),
        .d      (acc_shr)
    );

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state  <= S_IDLE;
            acc    <= '0;
            cnt    <= '0;
            id     <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            id     <= id_nxt;
            rr_ptr <= rr_ptr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        id_nxt        = id;
        rr_ptr_nxt    = rr_ptr;
        bus.req_ready = '0;
        bus.rsp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                // Gated by Rst so no accept pulse leaks out while reset is held.
                if (grant_any && Rst) begin
                    bus.req_ready = grant;
                    acc_nxt       = bus.req_a[grant_idx*DATAWIDTH +: DATAWIDTH];
                    cnt_nxt       = bus.req_amt[grant_idx*AMTWIDTH +: AMTWIDTH];
                    id_nxt        = grant_idx;
                    state_nxt     = (cnt_nxt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                acc_nxt = acc_shr;
                cnt_nxt = cnt - 1'b1;
                if (cnt == AMTWIDTH'(1)) state_nxt = S_DONE;
`ifdef SHR_EARLY_ZERO_EN
                if (acc_shr == '0) state_nxt = S_DONE;
`else
`endif
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    rr_ptr_nxt = (id == IDWIDTH'(NUM_REQ - 1)) ? '0 : id + 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.rsp_d  = acc;
    assign bus.rsp_id = id;
    assign bus.busy   = (state != S_IDLE);
endmodule

// File: tb/tb_shr_seq_arbiter.sv
// tb/tb_shr_seq_arbiter.sv - directed self-checking bench for shr_seq_arbiter
module tb_shr_seq_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    shr_seq_arbiter_if #(.NUM_REQ(2), .DATAWIDTH(16), .AMTWIDTH(4), .IDWIDTH(1)) bus ();

    shr_seq_arbiter #(.DATAWIDTH(16), .NUM_REQ(2), .AMTWIDTH(4), .IDWIDTH(1)) dut (
        .Clk (clk),
        .Rst (rst),
        .bus (bus)
    );

    task automatic drive_req(input int idx, input logic [15:0] a, input logic [3:0] amt);
        bus.req_valid[idx]      = 1'b1;
        bus.req_a[idx*16 +: 16] = a;
        bus.req_amt[idx*4 +: 4] = amt;
    endtask

    task automatic wait_accept(output logic [1:0] g);
        g = 2'b00;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.req_ready !== 2'b00) begin
                g = bus.req_ready;
                return;
            end
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_d !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_d got %h want 0000", bus.rsp_d); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got %b want 0", bus.rsp_id); end
        n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b want 00", bus.req_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_amt_zero();
        logic [1:0] g;
        int lat;
        @(posedge clk); #1 drive_req(1, 16'hABCD, 4'd0);
        wait_accept(g);
        n_cmp++; if (g !== 2'b10) begin n_fail++; $display("FAIL amt0_grant got %b want 10", g); end
        @(posedge clk); #1 bus.req_valid[1] = 1'b0;
        wait_rsp(lat);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL amt0_latency got %0d want 1", lat); end
        n_cmp++; if (bus.rsp_d !== 16'hABCD) begin n_fail++; $display("FAIL amt0_rsp_d got %h want abcd", bus.rsp_d); end
        n_cmp++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL amt0_rsp_id got %b want 1", bus.rsp_id); end
    endtask

    task automatic test_amt_max();
        logic [1:0] g;
        int lat;
        @(posedge clk); #1 drive_req(0, 16'h8000, 4'd15);
        wait_accept(g);
        n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL amt15_grant got %b want 01", g); end
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(lat);
        n_cmp++; if (lat !== 16) begin n_fail++; $display("FAIL amt15_latency got %0d want 16", lat); end
        n_cmp++; if (bus.rsp_d !== 16'h0001) begin n_fail++; $display("FAIL amt15_rsp_d got %h want 0001", bus.rsp_d); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL amt15_rsp_id got %b want 0", bus.rsp_id); end
    endtask

    task automatic test_reset_mid_shift();
        logic [1:0] g;
        logic seen;
        @(posedge clk); #1 drive_req(0, 16'hF000, 4'd8);
        wait_accept(g);
        n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL midrst_grant got %b want 01", g); end
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_rsp got %b want 0", seen); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    endtask

    task automatic test_alternate();
        logic [1:0] g;
        int lat;
        @(posedge clk); #1 drive_req(0, 16'h00F0, 4'd4); drive_req(1, 16'h00F0, 4'd4);
        for (int k = 0; k < 4; k++) begin
            wait_accept(g);
            n_cmp++; if (g !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL alt_grant[%0d] got %b want %b", k, g, (k % 2 == 0) ? 2'b01 : 2'b10); end
            wait_rsp(lat);
            n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL alt_latency[%0d] got %0d want 5", k, lat); end
            n_cmp++; if (bus.rsp_d !== 16'h000F) begin n_fail++; $display("FAIL alt_rsp_d[%0d] got %h want 000f", k, bus.rsp_d); end
            n_cmp++; if (bus.rsp_id !== 1'(k % 2)) begin n_fail++; $display("FAIL alt_rsp_id[%0d] got %b want %0d", k, bus.rsp_id, k % 2); end
        end
        @(posedge clk); #1 bus.req_valid = 2'b00;
    endtask

    task automatic test_stall();
        logic [1:0] g;
        int lat;
        @(posedge clk); #1 bus.rsp_ready = 1'b0; drive_req(1, 16'h1234, 4'd2);
        wait_accept(g);
        n_cmp++; if (g !== 2'b10) begin n_fail++; $display("FAIL stall_grant got %b want 10", g); end
        @(posedge clk); #1 bus.req_valid[1] = 1'b0; drive_req(0, 16'h00FF, 4'd1);
        wait_rsp(lat);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL stall_latency got %0d want 3", lat); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid[%0d] got %b want 1", i, bus.rsp_valid); end
            n_cmp++; if (bus.rsp_d !== 16'h048D) begin n_fail++; $display("FAIL stall_rsp_d[%0d] got %h want 048d", i, bus.rsp_d); end
            n_cmp++; if (bus.rsp_id !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_id[%0d] got %b want 1", i, bus.rsp_id); end
            n_cmp++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL stall_req_ready[%0d] got %b want 00", i, bus.req_ready); end
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL release_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL release_grant got %b want 01", bus.req_ready); end
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(lat);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL release_latency got %0d want 2", lat); end
        n_cmp++; if (bus.rsp_d !== 16'h007F) begin n_fail++; $display("FAIL release_rsp_d got %h want 007f", bus.rsp_d); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL release_rsp_id got %b want 0", bus.rsp_id); end
    endtask

    task automatic test_early_zero();
        logic [1:0] g;
        int lat;
        int want_lat;
`ifdef SHR_EARLY_ZERO_EN
        want_lat = 3;
`else
        want_lat = 13;
`endif
        @(posedge clk); #1 drive_req(0, 16'h0003, 4'd12);
        wait_accept(g);
        n_cmp++; if (g !== 2'b01) begin n_fail++; $display("FAIL ez_grant got %b want 01", g); end
        @(posedge clk); #1 bus.req_valid[0] = 1'b0;
        wait_rsp(lat);
        n_cmp++; if (lat !== want_lat) begin n_fail++; $display("FAIL ez_latency got %0d want %0d", lat, want_lat); end
        n_cmp++; if (bus.rsp_d !== 16'h0000) begin n_fail++; $display("FAIL ez_rsp_d got %h want 0000", bus.rsp_d); end
        n_cmp++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL ez_rsp_id got %b want 0", bus.rsp_id); end
    endtask

    initial begin
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_amt   = '0;
        bus.rsp_ready = 1'b1;
        test_reset();
        test_amt_zero();
        test_amt_max();
        test_reset_mid_shift();
        test_alternate();
        test_stall();
        test_early_zero();
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
